irq_request_unit: RTL and testbench

IRQ_REQUEST_UNIT -- requirements
Module: irq_request_unit

---
 rtl/irq_pkg.sv | 22 ++
 rtl/irq_debounce_line.sv | 126 ++++++++++++
 rtl/irq_request_unit.sv | 86 ++++++++
 tb/tb_irq_request_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// -----------------------------------------------------------------------------
// irq_pkg
// Shared constants and types for the push-button interrupt request unit.
//   N_IRQ                   : default number of request lines
//   IRQ_ID_W                : width of the irq_id index output
//   DEBOUNCE_CYCLES_DEFAULT : default stability time in clk cycles
//   db_state_t              : per-line debounce state
// -----------------------------------------------------------------------------
package irq_pkg;

  localparam int N_IRQ                   = 3;
  localparam int IRQ_ID_W                = 2;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 20;

  typedef enum logic [1:0] {
    DB_LOW       = 2'd0,
    DB_RISE_WAIT = 2'd1,
    DB_HIGH      = 2'd2,
    DB_FALL_WAIT = 2'd3
  } db_state_t;

endpackage

// File: rtl/irq_debounce_line.sv
// -----------------------------------------------------------------------------
// irq_debounce_line
// One request line: two-flop synchronizer for the raw button, then a debounce
// FSM with a saturating stability counter.
//   clk      : clock
//   rst      : raw asynchronous active-low reset (clears the synchronizer)
//   rst_sync : active-low reset with synchronized deassertion (FSM, counter)
//   btn      : raw asynchronous button level
//   level    : debounced button level (registered)
//   rise_evt : strobe, high in the cycle whose closing edge accepts a rise;
//              the owner samples it on that same edge
// -----------------------------------------------------------------------------
module irq_debounce_line
  import irq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic rst_sync,
  input  logic btn,
  output logic level,
  output logic rise_evt
);

  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       sync_q;
  logic             btn_sync;
  db_state_t        state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc;
  logic             rise_done;
  logic             fall_done;

  // The synchronizer is released straight from the raw reset so it is
  // already tracking the button while the FSM waits out the synchronized
  // reset release; a held button then needs exactly 2+DEBOUNCE_CYCLES edges
  // after release, the same as in normal operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn};
    end
  end

  assign btn_sync = sync_q[1];

  // Saturating increment: the counter can never wrap back to zero.
  assign count_inc = (count == CNT_MAX) ? count : count + CNT_ONE;

  // A change is accepted on the edge where the run of stable samples reaches
  // DEBOUNCE_CYCLES; for DEBOUNCE_CYCLES=1 that is the very first sample.
  assign rise_done = btn_sync &&
                     (((state == DB_LOW) && (CNT_ONE == CNT_MAX)) ||
                      ((state == DB_RISE_WAIT) && (count_inc == CNT_MAX)));
  assign fall_done = !btn_sync &&
                     (((state == DB_HIGH) && (CNT_ONE == CNT_MAX)) ||
                      ((state == DB_FALL_WAIT) && (count_inc == CNT_MAX)));

  assign rise_evt = rise_done;

  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      state <= DB_LOW;
      count <= '0;
      level <= 1'b0;
    end else begin
      case (state)
        DB_LOW: begin
          if (rise_done) begin
            state <= DB_HIGH;
            count <= '0;
            level <= 1'b1;
          end else if (btn_sync) begin
            state <= DB_RISE_WAIT;
            count <= CNT_ONE;
          end
        end
        DB_RISE_WAIT: begin
          if (!btn_sync) begin
            state <= DB_LOW;
            count <= '0;
          end else if (rise_done) begin
            state <= DB_HIGH;
            count <= '0;
            level <= 1'b1;
          end else begin
            count <= count_inc;
          end
        end
        DB_HIGH: begin
          if (fall_done) begin
            state <= DB_LOW;
            count <= '0;
            level <= 1'b0;
          end else if (!btn_sync) begin
            state <= DB_FALL_WAIT;
            count <= CNT_ONE;
          end
        end
        DB_FALL_WAIT: begin
          if (btn_sync) begin
            state <= DB_HIGH;
            count <= '0;
          end else if (fall_done) begin
            state <= DB_LOW;
            count <= '0;
            level <= 1'b0;
          end else begin
            count <= count_inc;
          end
        end
        default: begin
          state <= DB_LOW;
          count <= '0;
          level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/irq_request_unit.sv
// -----------------------------------------------------------------------------
// irq_request_unit
// Debounces N_IRQ push buttons, latches a pending request on each accepted
// press, flags presses that arrive while a request is still pending, and
// presents the highest-index pending line to the CPU.
//   clk         : clock
//   rst         : asynchronous active-low reset
//   btn         : raw button levels, bit i feeds line i
//   irq_ack     : one-cycle clear strobes, bit i clears line i
//   irq_pending : latched pending requests
//   irq_valid   : any request pending
//   irq_id      : index of the highest pending line, 0 when none
//   irq_overrun : sticky per-line "pressed again while pending"
//   btn_level   : debounced button levels
// -----------------------------------------------------------------------------
module irq_request_unit #(
  parameter int N_IRQ           = irq_pkg::N_IRQ,
  parameter int DEBOUNCE_CYCLES = irq_pkg::DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_IRQ-1:0]             btn,
  input  logic [N_IRQ-1:0]             irq_ack,
  output logic [N_IRQ-1:0]             irq_pending,
  output logic                         irq_valid,
  output logic [irq_pkg::IRQ_ID_W-1:0] irq_id,
  output logic [N_IRQ-1:0]             irq_overrun,
  output logic [N_IRQ-1:0]             btn_level
);

  localparam int ID_W = irq_pkg::IRQ_ID_W;

  logic [1:0]       rst_q;
  logic             rst_sync;
  logic [N_IRQ-1:0] rise_evt;

  // Reset asserts immediately but is released through two flops so every
  // state flop leaves reset on the same clean clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_q <= 2'b00;
    end else begin
      rst_q <= {rst_q[0], 1'b1};
    end
  end

  assign rst_sync = rst_q[1];

  for (genvar g = 0; g < N_IRQ; g++) begin : g_line
    irq_debounce_line #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_line (
      .clk      (clk),
      .rst      (rst),
      .rst_sync (rst_sync),
      .btn      (btn[g]),
      .level    (btn_level[g]),
      .rise_evt (rise_evt[g])
    );
  end

  // A rise on the same edge as an ack re-sets pending, so the new press is
  // kept; the ack still clears the overrun flag.
  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      irq_pending <= '0;
      irq_overrun <= '0;
    end else begin
      irq_pending <= (irq_pending & ~irq_ack) | rise_evt;
      irq_overrun <= ~irq_ack & (irq_overrun | (rise_evt & irq_pending));
    end
  end

  assign irq_valid = |irq_pending;

  // Ascending scan, so the highest set index is the one left in irq_id.
  always_comb begin
    irq_id = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (irq_pending[i]) begin
        irq_id = ID_W'(i);
      end
    end
  end

endmodule

// File: tb/tb_irq_request_unit.sv
// -----------------------------------------------------------------------------
// tb_irq_request_unit
// Scoreboard bench: every stimulus cycle pushes the reference model's
// expected outputs for the following edge; a monitor pops and compares one
// entry one time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_irq_request_unit;

  localparam int N  = 3;
  localparam int DC = 4;

  typedef struct {
    logic [N-1:0] pending;
    logic [N-1:0] overrun;
    logic [N-1:0] level;
    logic         valid;
    logic [1:0]   id;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn;
  logic [N-1:0] irq_ack;
  logic [N-1:0] irq_pending;
  logic         irq_valid;
  logic [1:0]   irq_id;
  logic [N-1:0] irq_overrun;
  logic [N-1:0] btn_level;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: button samples delayed two cycles, a run length of
  // samples disagreeing with the debounced level, and the request rules.
  logic [N-1:0] m_pend;
  logic [N-1:0] m_ov;
  logic [N-1:0] m_lvl;
  logic [N-1:0] m_s1;
  logic [N-1:0] m_s2;
  int           m_run[N];
  int           m_hold;

  irq_request_unit #(
    .N_IRQ(N),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn         (btn),
    .irq_ack     (irq_ack),
    .irq_pending (irq_pending),
    .irq_valid   (irq_valid),
    .irq_id      (irq_id),
    .irq_overrun (irq_overrun),
    .btn_level   (btn_level)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(logic [N-1:0] p, logic [N-1:0] o, logic [N-1:0] l,
                              logic v, logic [1:0] id);
    exp_t e;
    e.pending = p;
    e.overrun = o;
    e.level   = l;
    e.valid   = v;
    e.id      = id;
    return e;
  endfunction

  function automatic exp_t modelSnapshot();
    exp_t e;
    e.pending = m_pend;
    e.overrun = m_ov;
    e.level   = m_lvl;
    e.valid   = (m_pend != '0);
    e.id      = 2'd0;
    for (int i = 0; i < N; i++) begin
      if (m_pend[i]) e.id = 2'(i);
    end
    return e;
  endfunction

  // Advances the model across one rising edge with the given inputs.
  task automatic modelStep(input logic [N-1:0] b, input logic [N-1:0] a, input logic r);
    logic [N-1:0] evt;
    evt = '0;
    if (!r) begin
      m_pend = '0;
      m_ov   = '0;
      m_lvl  = '0;
      m_s1   = '0;
      m_s2   = '0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
      m_hold = 2;
    end else if (m_hold > 0) begin
      m_hold = m_hold - 1;
      m_s2   = m_s1;
      m_s1   = b;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (m_s2[i] != m_lvl[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] >= DC) begin
            m_lvl[i] = m_s2[i];
            m_run[i] = 0;
            evt[i]   = m_s2[i];
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_ov   = ~a & (m_ov | (evt & m_pend));
      m_pend = (m_pend & ~a) | evt;
      m_s2   = m_s1;
      m_s1   = b;
    end
  endtask

  task automatic checkOutput(input string name, input exp_t e);
    checks++;
    if (irq_pending !== e.pending || irq_overrun !== e.overrun ||
        btn_level !== e.level || irq_valid !== e.valid || irq_id !== e.id) begin
      errors++;
      $display("[TB] FAIL %s @%0t: got pend=%b ovr=%b lvl=%b valid=%b id=%0d, want pend=%b ovr=%b lvl=%b valid=%b id=%0d",
               name, $time, irq_pending, irq_overrun, btn_level, irq_valid, irq_id,
               e.pending, e.overrun, e.level, e.valid, e.id);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] b, input logic [N-1:0] a, input logic r);
    rst     = r;
    btn     = b;
    irq_ack = a;
    modelStep(b, a, r);
    exp_q.push_back(modelSnapshot());
    @(posedge clk);
    #2;
  endtask

  task automatic holdBtn(input logic [N-1:0] b, input int n);
    repeat (n) applyStimulus(b, '0, 1'b1);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("scoreboard", e);
      end
    end
  end

  initial begin
    logic [N-1:0] tgt;
    int           dur[N];
    int           rst_left;
    logic [N-1:0] a;

    rst     = 1'b0;
    btn     = '0;
    irq_ack = '0;
    m_hold  = 2;

    repeat (3) applyStimulus('0, '0, 1'b0);
    holdBtn('0, 4);
    checkOutput("reset_state", mk(3'b000, 3'b000, 3'b000, 1'b0, 2'd0));

    // Single press on line 0: pending after exactly 6 edges.
    holdBtn(3'b001, 5);
    checkOutput("press0_early", mk(3'b000, 3'b000, 3'b000, 1'b0, 2'd0));
    holdBtn(3'b001, 1);
    checkOutput("press0_latency", mk(3'b001, 3'b000, 3'b001, 1'b1, 2'd0));
    applyStimulus(3'b001, 3'b001, 1'b1);
    checkOutput("press0_ack", mk(3'b000, 3'b000, 3'b001, 1'b0, 2'd0));
    holdBtn(3'b000, 8);
    checkOutput("press0_release", mk(3'b000, 3'b000, 3'b000, 1'b0, 2'd0));

    // Glitch of three synchronized cycles on line 1.
    holdBtn(3'b010, 3);
    holdBtn(3'b000, 8);
    checkOutput("glitch1", mk(3'b000, 3'b000, 3'b000, 1'b0, 2'd0));

    // Lines 0 and 2 together: priority and selective acks.
    holdBtn(3'b101, 6);
    checkOutput("prio_both", mk(3'b101, 3'b000, 3'b101, 1'b1, 2'd2));
    applyStimulus(3'b000, 3'b100, 1'b1);
    checkOutput("prio_ack2", mk(3'b001, 3'b000, 3'b101, 1'b1, 2'd0));
    applyStimulus(3'b000, 3'b001, 1'b1);
    checkOutput("prio_ack0", mk(3'b000, 3'b000, 3'b101, 1'b0, 2'd0));
    holdBtn(3'b000, 8);

    // Overrun on line 1.
    holdBtn(3'b010, 6);
    checkOutput("ovr_first", mk(3'b010, 3'b000, 3'b010, 1'b1, 2'd1));
    holdBtn(3'b000, 8);
    holdBtn(3'b010, 6);
    checkOutput("ovr_second", mk(3'b010, 3'b010, 3'b010, 1'b1, 2'd1));
    applyStimulus(3'b010, 3'b010, 1'b1);
    checkOutput("ovr_ack", mk(3'b000, 3'b000, 3'b010, 1'b0, 2'd0));
    holdBtn(3'b000, 8);

    // Rise event on line 2 coincident with its ack.
    holdBtn(3'b100, 6);
    holdBtn(3'b000, 8);
    holdBtn(3'b100, 6);
    checkOutput("coinc_ovr", mk(3'b100, 3'b100, 3'b100, 1'b1, 2'd2));
    holdBtn(3'b000, 8);
    holdBtn(3'b100, 5);
    applyStimulus(3'b100, 3'b100, 1'b1);
    checkOutput("coinc_ack", mk(3'b100, 3'b000, 3'b100, 1'b1, 2'd2));
    holdBtn(3'b000, 8);

    // Reset in the middle of a press on line 0 (count at 3).
    holdBtn(3'b001, 5);
    checkOutput("rst_before", mk(3'b100, 3'b000, 3'b000, 1'b1, 2'd2));
    rst = 1'b0;
    #1;
    checkOutput("rst_immediate", mk(3'b000, 3'b000, 3'b000, 1'b0, 2'd0));
    applyStimulus(3'b001, 3'b000, 1'b0);
    applyStimulus(3'b001, 3'b000, 1'b0);
    holdBtn(3'b001, 5);
    checkOutput("rst_fresh_early", mk(3'b000, 3'b000, 3'b000, 1'b0, 2'd0));
    holdBtn(3'b001, 1);
    checkOutput("rst_fresh_pend", mk(3'b001, 3'b000, 3'b001, 1'b1, 2'd0));

    // Randomized phase: held levels of random length (short ones are
    // glitches), sparse random acks, occasional reset pulses.
    tgt      = 3'b001;
    rst_left = 0;
    for (int i = 0; i < N; i++) dur[i] = $urandom_range(1, 12);
    for (int step = 0; step < 3000; step++) begin
      for (int i = 0; i < N; i++) begin
        dur[i] = dur[i] - 1;
        if (dur[i] <= 0) begin
          tgt[i] = ~tgt[i];
          dur[i] = $urandom_range(1, 12);
        end
      end
      a = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      if (rst_left == 0 && $urandom_range(0, 299) == 0) rst_left = $urandom_range(1, 3);
      if (rst_left > 0) begin
        rst_left = rst_left - 1;
        applyStimulus(tgt, a, 1'b0);
      end else begin
        applyStimulus(tgt, a, 1'b1);
      end
    end

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
